// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// sequencer states and the register-index width.
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_e;

    // The M-stage producer is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_select(
        input logic                 wr_m,
        input logic [REG_IDX_W-1:0] rd_m,
        input logic                 wr_w,
        input logic [REG_IDX_W-1:0] rd_w,
        input logic [REG_IDX_W-1:0] rs
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != {REG_IDX_W{1'b0}}) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != {REG_IDX_W{1'b0}}) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle execute sequencer: holds E for MC_LATENCY cycles, stalling the
// front of the pipe for all but the last one, which is flagged as done.
module mc_sequencer
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic multi_cycle_i,
    output logic mc_stall_o,
    output logic ex_done_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_stall_s;
    logic             ex_done_s;

    // State and occupancy counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and stall/done decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_stall_s = 1'b0;
        ex_done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (multi_cycle_i) begin
                    mc_stall_s = 1'b1;
                    state_d    = ST_BUSY;
                    cnt_d      = CNT_LOAD;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != CNT_ZERO) begin
                    mc_stall_s = 1'b1;
                    cnt_d      = cnt_q - CNT_ONE;
                end else begin
                    ex_done_s  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Reset forces the controls low immediately, not just at the next edge.
    assign mc_stall_o = mc_stall_s & rst_ni;
    assign ex_done_o  = ex_done_s & rst_ni;
    assign busy_o     = (state_q == ST_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// multi-cycle sequencing. Perf counters are built only with HAZARD_PERF_CNT_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] Rs1_D,
    input  logic [REG_IDX_W-1:0] Rs2_D,
    input  logic [REG_IDX_W-1:0] Rs1_E,
    input  logic [REG_IDX_W-1:0] Rs2_E,
    input  logic [REG_IDX_W-1:0] RD_E,
    input  logic [REG_IDX_W-1:0] RD_M,
    input  logic [REG_IDX_W-1:0] RD_W,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MultiCycleE,
    output logic [1:0]           ForwardA_E,
    output logic [1:0]           ForwardB_E,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 ExDoneE,
    output logic [31:0]          LoadStallCnt,
    output logic [31:0]          MultiStallCnt,
    output logic [31:0]          FlushCnt
);

    logic mc_stall_s;
    logic ex_done_s;
    logic busy_s;
    logic lw_raw_s;
    logic lw_stall_s;
    logic br_s;

    mc_sequencer #(
        .MC_LATENCY (MC_LATENCY),
        .CNT_W      (CNT_W)
    ) u_mc_sequencer (
        .clk_i         (clk),
        .rst_ni        (rst),
        .multi_cycle_i (MultiCycleE),
        .mc_stall_o    (mc_stall_s),
        .ex_done_o     (ex_done_s),
        .busy_o        (busy_s)
    );

    // While busy the E slot holds a multi-cycle op, so load/branch inputs are stale.
    assign lw_raw_s   = ResultSrcE && (RD_E != {REG_IDX_W{1'b0}}) &&
                        ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    assign lw_stall_s = lw_raw_s & ~busy_s & rst;
    assign br_s       = PCSrcE & ~busy_s & rst;

    // Combinational hazard outputs; a taken branch overrides a load-use hold.
    always_comb begin
        ForwardA_E = FWD_RD;
        ForwardB_E = FWD_RD;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        ExDoneE    = 1'b0;
        if (rst) begin
            ForwardA_E = fwd_select(RegWriteM, RD_M, RegWriteW, RD_W, Rs1_E);
            ForwardB_E = fwd_select(RegWriteM, RD_M, RegWriteW, RD_W, Rs2_E);
            StallF     = mc_stall_s | (lw_stall_s & ~br_s);
            StallD     = mc_stall_s | (lw_stall_s & ~br_s);
            StallE     = mc_stall_s;
            FlushD     = br_s;
            FlushE     = lw_stall_s | br_s;
            FlushM     = mc_stall_s;
            ExDoneE    = ex_done_s;
        end else begin
            ForwardA_E = FWD_RD;
            ForwardB_E = FWD_RD;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] multi_cnt_q, multi_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    assign load_cnt_d  = lw_stall_s ? (load_cnt_q + 32'd1) : load_cnt_q;
    assign multi_cnt_d = mc_stall_s ? (multi_cnt_q + 32'd1) : multi_cnt_q;
    assign flush_cnt_d = br_s ? (flush_cnt_q + 32'd1) : flush_cnt_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q  <= 32'd0;
            multi_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            multi_cnt_q <= multi_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign LoadStallCnt  = load_cnt_q;
    assign MultiStallCnt = multi_cnt_q;
    assign FlushCnt      = flush_cnt_q;
`else
    assign LoadStallCnt  = 32'd0;
    assign MultiStallCnt = 32'd0;
    assign FlushCnt      = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// stimulus against an occupancy-index reference model.
module tb_hazard_controller;

    localparam int L = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, ExDoneE;
    logic [31:0] LoadStallCnt, MultiStallCnt, FlushCnt;

    int errors = 0;
    int checks = 0;

    hazard_controller #(.MC_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .ExDoneE(ExDoneE),
        .LoadStallCnt(LoadStallCnt), .MultiStallCnt(MultiStallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    // Reference model: m_occ is 0 when E is free, else the index of the
    // current cycle within a multi-cycle op (1..L-1).
    int          m_occ;
    logic [31:0] m_load, m_multi, m_flush;

    function automatic logic f_lw();
        return rst && (m_occ == 0) && ResultSrcE && (RD_E != 5'd0) &&
               ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    endfunction

    function automatic logic f_br();
        return rst && (m_occ == 0) && PCSrcE;
    endfunction

    function automatic logic f_mc();
        if (!rst) return 1'b0;
        if (m_occ == 0) return MultiCycleE;
        return (m_occ < L - 1);
    endfunction

    function automatic logic f_done();
        return rst && (m_occ != 0) && (m_occ == L - 1);
    endfunction

    function automatic logic [1:0] f_fwd(input logic [4:0] rs);
        if (!rst) return 2'd0;
        if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'd2;
        if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_occ <= 0; m_load <= 32'd0; m_multi <= 32'd0; m_flush <= 32'd0;
        end else if (m_occ == 0) begin
            if (f_lw()) m_load <= m_load + 32'd1;
            if (PCSrcE) m_flush <= m_flush + 32'd1;
            if (MultiCycleE) begin
                m_multi <= m_multi + 32'd1;
                m_occ   <= 1;
            end
        end else begin
            if (m_occ < L - 1) m_multi <= m_multi + 32'd1;
            m_occ <= (m_occ == L - 1) ? 0 : m_occ + 1;
        end
    end

    task automatic clear_inputs();
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
        RD_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 1'b0;
        PCSrcE = 1'b0; MultiCycleE = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        Rs1_E = 5'd5; Rs2_E = 5'd5; RD_M = 5'd5; RegWriteM = 1'b1;
        ResultSrcE = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7; PCSrcE = 1'b1; MultiCycleE = 1'b1;
        #1;
        checks++; if (ForwardA_E !== 2'b00) begin errors++; $display("FAIL rst_fwdA: got %b exp 00", ForwardA_E); end
        checks++; if (ForwardB_E !== 2'b00) begin errors++; $display("FAIL rst_fwdB: got %b exp 00", ForwardB_E); end
        checks++; if ({StallF, StallD, StallE, FlushD, FlushE, FlushM, ExDoneE} !== 7'b0)
            begin errors++; $display("FAIL rst_ctrl: got %b exp 0000000", {StallF, StallD, StallE, FlushD, FlushE, FlushM, ExDoneE}); end
        checks++; if ({LoadStallCnt, MultiStallCnt, FlushCnt} !== 96'd0)
            begin errors++; $display("FAIL rst_cnt: got %0d/%0d/%0d exp 0/0/0", LoadStallCnt, MultiStallCnt, FlushCnt); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++; if ({StallF, StallE, ExDoneE} !== 3'b0) begin errors++; $display("FAIL rst_release: got %b exp 000", {StallF, StallE, ExDoneE}); end
    endtask

    task automatic test_forwarding();
        do_reset();
        @(negedge clk);
        Rs1_E = 5'd5; Rs2_E = 5'd5; RD_M = 5'd5; RegWriteM = 1'b1; RD_W = 5'd5; RegWriteW = 1'b1;
        #1;
        checks++; if (ForwardA_E !== 2'b10) begin errors++; $display("FAIL fwdA_m_prio: got %b exp 10", ForwardA_E); end
        checks++; if (ForwardB_E !== 2'b10) begin errors++; $display("FAIL fwdB_m_prio: got %b exp 10", ForwardB_E); end
        @(negedge clk);
        RegWriteM = 1'b0;
        #1;
        checks++; if (ForwardA_E !== 2'b01) begin errors++; $display("FAIL fwdA_w: got %b exp 01", ForwardA_E); end
        @(negedge clk);
        RD_M = 5'd0; RD_W = 5'd0; RegWriteM = 1'b1; Rs1_E = 5'd0;
        #1;
        checks++; if (ForwardA_E !== 2'b00) begin errors++; $display("FAIL fwdA_x0: got %b exp 00", ForwardA_E); end
        @(negedge clk);
        Rs1_E = 5'd5; Rs2_E = 5'd6; RD_M = 5'd6; RegWriteM = 1'b1; RD_W = 5'd9; RegWriteW = 1'b1;
        #1;
        checks++; if (ForwardB_E !== 2'b10) begin errors++; $display("FAIL fwdB_m: got %b exp 10", ForwardB_E); end
        checks++; if (ForwardA_E !== 2'b00) begin errors++; $display("FAIL fwdA_nomatch: got %b exp 00", ForwardA_E); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        ResultSrcE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7; Rs1_D = 5'd3;
        #1;
        checks++; if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100)
            begin errors++; $display("FAIL lw_stall: got %b exp 11100", {StallF, StallD, FlushE, StallE, FlushD}); end
        @(negedge clk);
        ResultSrcE = 1'b0; RD_E = 5'd0;
        #1;
        checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL lw_bubble: got %b exp 000", {StallF, StallD, FlushE}); end
        @(negedge clk);
        ResultSrcE = 1'b1; RD_E = 5'd0; Rs2_D = 5'd0;
        #1;
        checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL lw_x0: got %b exp 000", {StallF, StallD, FlushE}); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (LoadStallCnt !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lw_cnt: got %0d exp %0d", LoadStallCnt, PERF ? 1 : 0); end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        PCSrcE = 1'b1;
        #1;
        checks++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100)
            begin errors++; $display("FAIL br_flush: got %b exp 1100", {FlushD, FlushE, StallF, StallD}); end
        @(negedge clk);
        PCSrcE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7;
        #1;
        checks++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100)
            begin errors++; $display("FAIL br_over_lw: got %b exp 1100", {FlushD, FlushE, StallF, StallD}); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (FlushCnt !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL br_cnt: got %0d exp %0d", FlushCnt, PERF ? 2 : 0); end
    endtask

    task automatic test_multicycle();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            MultiCycleE = (k < 4);
            #1;
            checks++; if ({StallF, StallD, StallE, FlushM} !== {4{k < 3}})
                begin errors++; $display("FAIL mc_stall c%0d: got %b exp %b", k, {StallF, StallD, StallE, FlushM}, {4{k < 3}}); end
            checks++; if (ExDoneE !== (k == 3)) begin errors++; $display("FAIL mc_done c%0d: got %b exp %b", k, ExDoneE, k == 3); end
        end
        checks++; if (MultiStallCnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL mc_cnt: got %0d exp %0d", MultiStallCnt, PERF ? 3 : 0); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_stall;
        logic [8:0] exp_done;
        exp_stall = 9'b0_0111_0111;
        exp_done  = 9'b0_1000_1000;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            MultiCycleE = (k < 8);
            #1;
            checks++; if (StallE !== exp_stall[k] || StallF !== exp_stall[k])
                begin errors++; $display("FAIL b2b_stall c%0d: got %b%b exp %b", k, StallE, StallF, exp_stall[k]); end
            checks++; if (ExDoneE !== exp_done[k]) begin errors++; $display("FAIL b2b_done c%0d: got %b exp %b", k, ExDoneE, exp_done[k]); end
        end
        checks++; if (MultiStallCnt !== (PERF ? 32'd6 : 32'd0)) begin errors++; $display("FAIL b2b_cnt: got %0d exp %0d", MultiStallCnt, PERF ? 6 : 0); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        @(negedge clk);
        MultiCycleE = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (StallE !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b exp 1", StallE); end
        rst = 1'b0;
        #1;
        checks++; if ({StallF, StallD, StallE, FlushM, ExDoneE} !== 5'b0)
            begin errors++; $display("FAIL mid_busy_async: got %b exp 00000", {StallF, StallD, StallE, FlushM, ExDoneE}); end
        checks++; if (MultiStallCnt !== 32'd0) begin errors++; $display("FAIL mid_busy_cnt: got %0d exp 0", MultiStallCnt); end
        @(negedge clk);
        MultiCycleE = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++; if ({StallE, ExDoneE} !== 2'b00)
                begin errors++; $display("FAIL mid_busy_after c%0d: got %b exp 00", k, {StallE, ExDoneE}); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
            RD_W  = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 1'($urandom_range(0, 1));
            PCSrcE      = ($urandom_range(0, 4) == 0);
            MultiCycleE = ($urandom_range(0, 5) == 0);
            #1;
            checks++; if (ForwardA_E !== f_fwd(Rs1_E)) begin errors++; $display("FAIL rnd_fwdA n%0d: got %b exp %b", n, ForwardA_E, f_fwd(Rs1_E)); end
            checks++; if (ForwardB_E !== f_fwd(Rs2_E)) begin errors++; $display("FAIL rnd_fwdB n%0d: got %b exp %b", n, ForwardB_E, f_fwd(Rs2_E)); end
            checks++; if (StallF !== (f_mc() || (f_lw() && !f_br())) || StallD !== StallF)
                begin errors++; $display("FAIL rnd_stallFD n%0d: got %b%b exp %b", n, StallF, StallD, f_mc() || (f_lw() && !f_br())); end
            checks++; if (StallE !== f_mc() || FlushM !== f_mc())
                begin errors++; $display("FAIL rnd_stallE n%0d: got %b%b exp %b", n, StallE, FlushM, f_mc()); end
            checks++; if (FlushD !== f_br() || FlushE !== (f_br() || f_lw()))
                begin errors++; $display("FAIL rnd_flush n%0d: got %b%b exp %b%b", n, FlushD, FlushE, f_br(), f_br() || f_lw()); end
            checks++; if (ExDoneE !== f_done()) begin errors++; $display("FAIL rnd_done n%0d: got %b exp %b", n, ExDoneE, f_done()); end
            checks++; if (LoadStallCnt !== (PERF ? m_load : 32'd0) || MultiStallCnt !== (PERF ? m_multi : 32'd0) ||
                          FlushCnt !== (PERF ? m_flush : 32'd0))
                begin errors++; $display("FAIL rnd_cnt n%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", n, LoadStallCnt, MultiStallCnt, FlushCnt,
                      PERF ? m_load : 0, PERF ? m_multi : 0, PERF ? m_flush : 0); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multicycle();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
